wb_regfile: RTL
===============

Name: wb_regfile

Overview:
- Consumer end of the MEM/WB write-back interface: the 32x32 general-purpose register file.
- Commits the write-back stage's register writes (with byte write-enables) and serves two combinational read ports to ID, with same-cycle write-through bypass.
- Records every committed write (pc, address, mask, resulting value) in a small commit-trace FIFO. A debug/trace consumer drains the FIFO over a valid/ready port.

Parameters:
- TRACE_DEPTH, 8, number of trace FIFO entries (power of two, ≥2).
- TRACE_PTR_W, 3, log2(TRACE_DEPTH).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- wb_wd  in  5  write-back destination register address.
- wb_wreg  in  4  byte write-enable mask; bit i enables byte i (bits [8i+7:8i]); 4'b0000 means no write.
- wb_wdata  in  32  write-back data.
- wb_pc  in  32  pc of the committing instruction.
- re1  in  1  read port 1 enable.
- raddr1  in  5  read port 1 address.
- rdata1  out  32  read port 1 data.
- re2  in  1  read port 2 enable.
- raddr2  in  5  read port 2 address.
- rdata2  out  32  read port 2 data.
- trace_valid  out  1  FIFO head entry available.
- trace_ready  in  1  consumer accepts head entry.
- trace_pc  out  32  head entry pc.
- trace_addr  out  5  head entry register address.
- trace_mask  out  4  head entry byte mask.
- trace_data  out  32  head entry full 32-bit register value after the write.
- trace_count  out  TRACE_PTR_W+1  entries currently held.
- trace_overflow  out  1  sticky flag: an entry was dropped.

Behaviour:
- Reset (rst=1 at posedge):
  - All 32 registers cleared to 0.
  - FIFO emptied: pointers 0, trace_count=0, trace_valid=0, trace_overflow=0.
  - trace_pc, trace_addr, trace_mask, trace_data read 0 while empty.
  - rst dominates any same-cycle write, push or pop.
  - While rst=1, rdata1 and rdata2 are forced to 0.
- Commit:
  - A commit occurs when wb_wreg≠0 and wb_wd≠0.
  - At posedge, byte i of reg[wb_wd] takes wb_wdata byte i when wb_wreg[i]=1; other bytes hold.
  - A write to register 0 is ignored and not traced; reg[0] always reads 0.
- Read ports (combinational, per port n):
  - If rst=1, or re_n=0, or raddr_n=0: rdata_n=0.
  - Else, if a commit is active and raddr_n==wb_wd: rdata_n = merged value. Merged value = wb_wdata bytes where mask=1, stored bytes elsewhere (bypass).
  - Else: rdata_n = reg[raddr_n].
  - Both ports may read the same address at the same time.
- Trace push:
  - Every commit pushes {wb_pc, wb_wd, wb_wreg, merged value} at the same posedge as the register write.
  - The entry is visible on the trace outputs the following cycle (1-cycle latency).
- Trace pop:
  - A pop occurs when trace_valid && trace_ready at posedge.
  - trace_ready is ignored when the FIFO is empty.
  - trace_valid = (trace_count≠0). Head outputs are driven from the read pointer; no bubble between back-to-back entries.
- Boundaries:
  - Pointers wrap modulo TRACE_DEPTH; trace_count ranges 0..TRACE_DEPTH.
  - Full with push and pop in the same cycle: both happen, count stays TRACE_DEPTH, no drop.
  - Full with push and no pop: the new entry is dropped, contents unchanged, trace_overflow←1. The flag stays set until rst.
  - Empty with push and trace_ready=1: no pop; count becomes 1.
  - Reset mid-stream discards all pending entries.
- Widths: trace_count is TRACE_PTR_W+1 bits so it can represent full.

Optional Feature:
- Macro WB_TRACE_EN.
- Defined: the trace FIFO and trace port are implemented as above.
- Undefined:
  - No FIFO storage is built.
  - trace_valid, trace_pc, trace_addr, trace_mask, trace_data, trace_count and trace_overflow are tied to 0; trace_ready is ignored.
  - Register file and read-port behaviour are identical.

Test Plan:
- Reset then read: rst=1 for 2 cycles, then read addresses 1..31 with re=1 -> all rdata=0, trace_valid=0, trace_count=0.
- Byte write: write reg5=0x11223344 with mask 4'hF, then 0xAABBCCDD with mask 4'b0101 -> reg5 reads 0x11BB33DD. The second trace entry carries mask 4'b0101 and data 0x11BB33DD.
- Bypass and r0: in the same cycle as write reg7=0xDEADBEEF (mask F), read raddr1=7 -> rdata1=0xDEADBEEF. Write reg0=0x1234 -> reads 0, no trace entry; with re2=0 on raddr2=7 -> rdata2=0.
- Trace ordering/latency: 3 commits (pc 0x100, 0x104, 0x108) with trace_ready=0 -> trace_count=3 one cycle after the last. Then hold trace_ready=1 -> entries pop in order on consecutive cycles, then trace_valid=0.
- Overflow: 9 commits with trace_ready=0 (depth 8) -> count=8, trace_overflow=1, the 9th entry is absent. With full FIFO, push plus trace_ready=1 in the same cycle -> count stays 8 and the overflow flag does not re-trigger a drop.
- Reset mid-stream: 4 entries pending, assert rst for one cycle -> count=0, overflow=0, registers read 0.

Source files
------------

// File: rtl/wb_regfile.sv
// -----------------------------------------------------------------------------
// wb_regfile
//
// 32 x 32-bit general-purpose register file at the consumer end of the
// MEM/WB write-back interface.
//   - Commits write-back writes with per-byte enables.
//   - Two combinational read ports for ID, with same-cycle write-through
//     bypass of the merged (byte-masked) write value.
//   - Optional commit-trace FIFO, built only when WB_TRACE_EN is defined.
//     Every committed write is recorded as {pc, addr, mask, resulting value}
//     and drained by a debug consumer over a valid/ready port. With the
//     macro undefined, no FIFO storage exists and every trace output is 0.
//
// Ports:
//   clk            system clock, all state updates on posedge
//   rst            synchronous, active-high reset
//   wb_wd          write-back destination register address
//   wb_wreg        byte write-enable mask (bit i -> bits [8i+7:8i]); 0 = no write
//   wb_wdata       write-back data
//   wb_pc          pc of the committing instruction
//   re1/raddr1     read port 1 enable / address
//   rdata1         read port 1 data
//   re2/raddr2     read port 2 enable / address
//   rdata2         read port 2 data
//   trace_valid    FIFO head entry available
//   trace_ready    consumer accepts head entry
//   trace_pc       head entry pc
//   trace_addr     head entry register address
//   trace_mask     head entry byte mask
//   trace_data     head entry full register value after the write
//   trace_count    entries currently held (0..TRACE_DEPTH)
//   trace_overflow sticky: an entry was dropped because the FIFO was full
//
// Parameters:
//   TRACE_DEPTH    trace FIFO entries (power of two, >= 2)
//   TRACE_PTR_W    log2(TRACE_DEPTH)
// -----------------------------------------------------------------------------
module wb_regfile #(
  parameter int TRACE_DEPTH = 8,
  parameter int TRACE_PTR_W = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [4:0]             wb_wd,
  input  logic [3:0]             wb_wreg,
  input  logic [31:0]            wb_wdata,
  input  logic [31:0]            wb_pc,
  input  logic                   re1,
  input  logic [4:0]             raddr1,
  output logic [31:0]            rdata1,
  input  logic                   re2,
  input  logic [4:0]             raddr2,
  output logic [31:0]            rdata2,
  output logic                   trace_valid,
  input  logic                   trace_ready,
  output logic [31:0]            trace_pc,
  output logic [4:0]             trace_addr,
  output logic [3:0]             trace_mask,
  output logic [31:0]            trace_data,
  output logic [TRACE_PTR_W:0]   trace_count,
  output logic                   trace_overflow
);

  // ---------------------------------------------------------------------------
  // Register array and commit
  // ---------------------------------------------------------------------------
  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];

  logic        commit;
  logic [31:0] wr_old;
  logic [31:0] wr_merged;

  // The merged value is shared by the register write, the read bypass and
  // the trace entry, so all three see exactly the same bytes.
  always_comb begin
    commit    = (wb_wreg != 4'b0000) && (wb_wd != 5'd0);
    wr_old    = regs_q[wb_wd];
    wr_merged = wr_old;
    for (int i = 0; i < 4; i++) begin
      if (wb_wreg[i]) begin
        wr_merged[8*i +: 8] = wb_wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    regs_d = regs_q;
    if (commit) begin
      regs_d[wb_wd] = wr_merged;
    end
  end

  // reg[0] is never written because commit excludes address 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports with write-through bypass
  // ---------------------------------------------------------------------------
  always_comb begin
    rdata1 = '0;
    if (!rst && re1 && (raddr1 != 5'd0)) begin
      if (commit && (raddr1 == wb_wd)) begin
        rdata1 = wr_merged;
      end else begin
        rdata1 = regs_q[raddr1];
      end
    end
  end

  always_comb begin
    rdata2 = '0;
    if (!rst && re2 && (raddr2 != 5'd0)) begin
      if (commit && (raddr2 == wb_wd)) begin
        rdata2 = wr_merged;
      end else begin
        rdata2 = regs_q[raddr2];
      end
    end
  end

`ifdef WB_TRACE_EN
  // ---------------------------------------------------------------------------
  // Commit-trace FIFO
  // ---------------------------------------------------------------------------
  localparam int                  CNT_W   = TRACE_PTR_W + 1;
  localparam logic [CNT_W-1:0]    DEPTH_C = CNT_W'(TRACE_DEPTH);
  localparam logic [CNT_W-1:0]    CNT_ONE = CNT_W'(1);
  localparam logic [TRACE_PTR_W-1:0] PTR_ONE = TRACE_PTR_W'(1);

  logic [31:0]            fifo_pc_q   [TRACE_DEPTH];
  logic [4:0]             fifo_addr_q [TRACE_DEPTH];
  logic [3:0]             fifo_mask_q [TRACE_DEPTH];
  logic [31:0]            fifo_data_q [TRACE_DEPTH];

  logic [TRACE_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [TRACE_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q,  count_d;
  logic                   overflow_q, overflow_d;

  logic fifo_full;
  logic fifo_pop;
  logic fifo_push;

  // A pop in the same cycle frees the slot, so a full FIFO still accepts
  // the push; only push-without-pop on full drops the entry.
  always_comb begin
    fifo_full  = (count_q == DEPTH_C);
    fifo_pop   = (count_q != '0) && trace_ready;
    fifo_push  = commit && (!fifo_full || fifo_pop);

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (fifo_push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (fifo_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    if (fifo_push && !fifo_pop) begin
      count_d = count_q + CNT_ONE;
    end else if (!fifo_push && fifo_pop) begin
      count_d = count_q - CNT_ONE;
    end
    if (commit && fifo_full && !fifo_pop) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: the head outputs are gated by trace_valid.
  always_ff @(posedge clk) begin
    if (!rst && fifo_push) begin
      fifo_pc_q[wr_ptr_q]   <= wb_pc;
      fifo_addr_q[wr_ptr_q] <= wb_wd;
      fifo_mask_q[wr_ptr_q] <= wb_wreg;
      fifo_data_q[wr_ptr_q] <= wr_merged;
    end
  end

  always_comb begin
    trace_valid    = (count_q != '0);
    trace_count    = count_q;
    trace_overflow = overflow_q;
    trace_pc       = '0;
    trace_addr     = '0;
    trace_mask     = '0;
    trace_data     = '0;
    if (trace_valid) begin
      trace_pc   = fifo_pc_q[rd_ptr_q];
      trace_addr = fifo_addr_q[rd_ptr_q];
      trace_mask = fifo_mask_q[rd_ptr_q];
      trace_data = fifo_data_q[rd_ptr_q];
    end
  end
`else
  // ---------------------------------------------------------------------------
  // Trace disabled: port tied off, consumer handshake ignored
  // ---------------------------------------------------------------------------
  logic unused_trace;
  assign unused_trace   = ^{trace_ready, wb_pc, TRACE_DEPTH[0]};

  assign trace_valid    = 1'b0;
  assign trace_pc       = '0;
  assign trace_addr     = '0;
  assign trace_mask     = '0;
  assign trace_data     = '0;
  assign trace_count    = '0;
  assign trace_overflow = 1'b0;
`endif

endmodule
